// File: rtl/inst_sram_pkg.sv
// rtl/inst_sram_pkg.sv - shared state encoding, reset PC and LFSR constants for inst_sram
package inst_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [31:0] RESET_PC   = 32'h80000000;
  localparam logic [7:0]  LFSR_SEED  = 8'h5A;
  // x^8+x^6+x^5+x^4+1 mapped onto bits 7,5,4,3
  localparam logic [7:0]  LFSR_TAPS  = 8'b1011_1000;

endpackage

// File: rtl/inst_sram_lfsr.sv
// rtl/inst_sram_lfsr.sv - free-running 8-bit Fibonacci LFSR supplying per-request delay bits
module inst_sram_lfsr
  import inst_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] rnd
);

  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

  assign rnd = lfsr[2:0];

endmodule

// File: rtl/inst_sram.sv
// rtl/inst_sram.sv - preloadable instruction SRAM with fixed-latency valid/ready fetch port
// Optional random per-request latency with INST_SRAM_RAND_DELAY_EN.
module inst_sram
  import inst_sram_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter logic [31:0] BASE    = RESET_PC,
  parameter int          LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_idx,
  input  logic [31:0]       ld_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [3:0]  lat_m1;
  logic [31:0] rd_addr;
  logic [31:0] off;
  logic        in_range;
  logic [31:0] rd_word;

`ifdef INST_SRAM_RAND_DELAY_EN
  logic [2:0] rnd;

  inst_sram_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  assign lat_m1 = {1'b0, rnd};
`else
  assign lat_m1 = 4'(LATENCY - 1);
`endif

  // Preload port is independent of the FSM and of reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  // In IDLE the read targets the address being accepted (LATENCY=1 path).
  assign rd_addr  = (state == ST_IDLE) ? req_addr : addr_q;
  assign off      = rd_addr - BASE;
  assign in_range = (rd_addr[1:0] == 2'b00) && (off < (32'd4 << ADDR_W));
  assign rd_word  = in_range ? mem[off[ADDR_W+1:2]] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'h0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (lat_m1 == 4'd0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= rd_word;
              rsp_err   <= !in_range;
            end else begin
              state <= ST_WAIT;
              cnt   <= lat_m1 - 4'd1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= rd_word;
            rsp_err   <= !in_range;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sram.sv
// tb/tb_inst_sram.sv - self-checking bench for inst_sram (instances with LATENCY 1 and 3)
module tb_inst_sram;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int          LAT0 = 1;
  localparam int          LAT1 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid [2];
  logic          req_ready [2];
  logic [31:0]   req_addr  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [31:0]   rsp_data  [2];
  logic          rsp_err   [2];
  logic          ld_en;
  logic [AW-1:0] ld_idx;
  logic [31:0]   ld_data;

  logic [31:0] model [1 << AW];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_sram #(.ADDR_W(AW), .BASE(BASE), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  inst_sram #(.ADDR_W(AW), .BASE(BASE), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  typedef struct {
    int          sel;
    logic [31:0] addr;
    int          hold;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a word is returned only for aligned addresses inside the window.
  task automatic ref_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    longint unsigned ua = a;
    longint unsigned ub = BASE;
    if (ua >= ub && ua < ub + 4 * (1 << AW) && a % 4 == 0) begin
      d = model[(ua - ub) / 4];
      e = 1'b0;
    end else begin
      d = 32'h0;
      e = 1'b1;
    end
  endtask

  task automatic txn(input int sel, input logic [31:0] addr, input int hold,
                     input bit do_ld, input logic [AW-1:0] li, input logic [31:0] ldv,
                     input logic [31:0] ed, input logic ee, input int el, input string tag);
    int lat = 0;
    int t = 0;
    bit ok_busy = 1'b1;
    bit ok_zero = 1'b1;
    bit ok_stab = 1'b1;
    logic [31:0] d0;
    logic        e0;
    while (!req_ready[sel] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_wait"}, 32'(req_ready[sel]), 32'd1);
    if (!req_ready[sel]) return;
    req_valid[sel] = 1'b1;
    req_addr[sel]  = addr;
    if (do_ld) begin
      ld_en = 1'b1; ld_idx = li; ld_data = ldv;
    end
    @(posedge clk);
    #1;
    req_valid[sel] = 1'b0;
    ld_en = 1'b0;
    if (do_ld) model[li] = ldv;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready[sel]) ok_busy = 1'b0;
      if (!rsp_valid[sel] && (rsp_data[sel] != 32'h0 || rsp_err[sel])) ok_zero = 1'b0;
    end while (!rsp_valid[sel] && lat < 40);
`ifdef INST_SRAM_RAND_DELAY_EN
    chk({tag, "_lat_range"}, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
    chk({tag, "_latency"}, 32'(lat), 32'(el));
`endif
    chk({tag, "_data"}, rsp_data[sel], ed);
    chk({tag, "_err"}, 32'(rsp_err[sel]), 32'(ee));
    d0 = rsp_data[sel];
    e0 = rsp_err[sel];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!rsp_valid[sel] || rsp_data[sel] !== d0 || rsp_err[sel] !== e0 || req_ready[sel])
        ok_stab = 1'b0;
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[sel] = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(req_ready[sel]), 32'd1);
    chk({tag, "_idle_outputs"}, {rsp_data[sel][30:0], rsp_valid[sel]}, 32'h0);
    chk({tag, "_busy_zero_stable"}, 32'({ok_busy, ok_zero, ok_stab}), 32'h7);
  endtask

  task automatic thr(input int sel, input int exp_cnt);
    int cnt = 0;
    int t = 0;
    while (!req_ready[sel] && t < 50) begin @(negedge clk); t++; end
    rsp_ready[sel] = 1'b1;
    req_valid[sel] = 1'b1;
    req_addr[sel]  = BASE + 32'h8;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid[sel]) cnt++;
      @(negedge clk);
    end
    req_valid[sel] = 1'b0;
    t = 0;
    while ((rsp_valid[sel] || !req_ready[sel]) && t < 50) begin @(negedge clk); t++; end
    rsp_ready[sel] = 1'b0;
    chk($sformatf("throughput_%0d", sel), 32'(cnt), 32'(exp_cnt));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed, a;
    logic        ee;
    int          sel, nrand;
    rst = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_data = 32'h0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = 32'h0; rsp_ready[s] = 1'b0;
    end
    @(negedge clk);
    // Preload happens entirely while rst is held.
    for (int i = 0; i < (1 << AW); i++) begin
      model[i] = (i == 0) ? 32'h00000413 : 32'(i + 1) * 32'h9E3779B9;
      ld_en = 1'b1; ld_idx = AW'(i); ld_data = model[i];
      @(negedge clk);
    end
    ld_en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_outputs_%0d", s),
          {rsp_data[s][29:0], rsp_err[s], rsp_valid[s] | req_ready[s]}, 32'h0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tbl[0] = '{0, 32'h80000000, 0, 32'h00000413, 1'b0, LAT0};
    tbl[1] = '{1, 32'h80000010, 4, model[4],     1'b0, LAT1};
    tbl[2] = '{0, 32'h80000002, 0, 32'h0,        1'b1, LAT0};
    tbl[3] = '{0, 32'h80000400, 0, 32'h0,        1'b1, LAT0};
    tbl[4] = '{1, 32'h80000002, 1, 32'h0,        1'b1, LAT1};
    tbl[5] = '{1, 32'h800003FC, 0, model[255],   1'b0, LAT1};
    tbl[6] = '{0, 32'h7FFFFFFC, 0, 32'h0,        1'b1, LAT0};
    tbl[7] = '{1, 32'h80000400, 2, 32'h0,        1'b1, LAT1};
    for (int v = 0; v < 8; v++)
      txn(tbl[v].sel, tbl[v].addr, tbl[v].hold, 1'b0, '0, 32'h0,
          tbl[v].data, tbl[v].err, tbl[v].lat, $sformatf("vec%0d", v));

`ifndef INST_SRAM_RAND_DELAY_EN
    // Write into idx 2 in the cycle that enters RESP: old value must come back.
    ed = model[2];
    txn(0, 32'h80000008, 0, 1'b1, AW'(2), 32'hCAFEF00D, ed, 1'b0, LAT0, "rbw_old");
    txn(0, 32'h80000008, 0, 1'b0, '0, 32'h0, 32'hCAFEF00D, 1'b0, LAT0, "rbw_new");
    thr(0, 10);
    thr(1, 5);
`endif

    // Reset one cycle after accept discards the request.
    while (!req_ready[1]) @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h80000004; rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {rsp_data[1][29:0], rsp_err[1], rsp_valid[1] | req_ready[1]}, 32'h0);
    rst = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (rsp_valid[1]) seen = 1'b1;
      end
      chk("midrst_no_rsp", 32'(seen), 32'd0);
    end
    rsp_ready[1] = 1'b0;
    txn(1, 32'h80000004, 0, 1'b0, '0, 32'h0, model[1], 1'b0, LAT1, "after_rst");

`ifdef INST_SRAM_RAND_DELAY_EN
    nrand = 1000;
`else
    nrand = 200;
`endif
    for (int n = 0; n < nrand; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = BASE + 4 * $urandom_range(0, 255);
        6:                a = BASE + 4 * $urandom_range(0, 255) + $urandom_range(1, 3);
        7:                a = BASE + 32'h400 + 4 * $urandom_range(0, 63);
        8:                a = BASE - 4 * $urandom_range(1, 64);
        default:          a = $urandom;
      endcase
      sel = $urandom_range(0, 1);
      ref_rd(a, ed, ee);
      txn(sel, a, $urandom_range(0, 3), 1'b0, '0, 32'h0, ed, ee,
          (sel == 0) ? LAT0 : LAT1, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) begin
        ld_en = 1'b1; ld_idx = AW'($urandom_range(0, 255)); ld_data = $urandom;
        @(posedge clk);
        #1;
        model[ld_idx] = ld_data;
        ld_en = 1'b0;
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
